dwc_and_checker: RTL and testbench
==================================

# dwc_and_checker

Parametrised duplication-with-comparison (DwC) datapath stage, successor to the single-bit DwC AND cell. Two identical lanes compute the bitwise AND of two WIDTH-bit operands through DEPTH pipeline registers each. Lane outputs are compared at the pipeline end, and the block keeps error bookkeeping: a per-item mismatch flag, a sticky flag, a saturating error counter and a fatal alarm on consecutive mismatches. A fault-injection port gives fault-verification benches a controlled way to make the lanes diverge.

## Interface
- WIDTH, 8: operand/result width, ≥1
- DEPTH, 1: register stages per lane, ≥1
- CNT_W, 8: error counter width, ≥1
- FATAL_THRESH, 3: consecutive mismatches that raise err_fatal, 1..2^CNT_W−1
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input item present this cycle
- in_a  in  WIDTH  operand A
- in_b  in  WIDTH  operand B
- fault_inj  in  WIDTH  XOR mask applied to lane 1 stage-0 input (0 in mission mode)
- cmp_en  in  1  comparison enable; 0 masks all mismatches
- err_clear  in  1  clears err_sticky, err_count and the consecutive counter
- out_valid  out  1  result present
- out_data  out  WIDTH  lane 0 result
- out_error  out  1  lane mismatch on the current output item
- err_sticky  out  1  at least one mismatch since the last clear
- err_count  out  CNT_W  saturating mismatch count
- err_fatal  out  1  consecutive-mismatch alarm; cleared only by rst

## Operation
- Lane 0 stage-0 input is in_a & in_b. Lane 1 stage-0 input is (in_a & in_b) ^ fault_inj. Each lane shifts through DEPTH registers every cycle.
- A single valid shift register of DEPTH bits runs alongside the lanes. out_valid is its last bit.
- out_data is the last register of lane 0.
- mismatch = out_valid & cmp_en & (lane0_last != lane1_last). This is XOR-style: 1 means error.
- out_error = mismatch, combinational from the final registers.
- Internal consecutive counter consec, width CNT_W, saturating:
  - mismatch: consec +1
  - out_valid & !mismatch: consec ← 0
  - out_valid=0 (bubble): consec unchanged
- On mismatch: err_sticky ← 1; err_count +1, saturating at 2^CNT_W−1.
- err_fatal ← 1 when the updated consec ≥ FATAL_THRESH. It stays 1 until rst. err_clear does not affect it.
- err_clear in the same cycle as a mismatch: the clear applies first, then the mismatch is recorded. Result: err_sticky=1, err_count=1, consec=1.
- Setting cmp_en=0 while an item is in flight only masks the comparison. The pipeline is unaffected.
- No backpressure. Throughput is one item per cycle.

## Timing
- Latency: an item accepted at edge k appears on out_data/out_valid after edge k+DEPTH−1, i.e. DEPTH cycles after in_valid is sampled.
- out_error is valid in the same cycle as out_data.
- err_sticky, err_count and err_fatal update on the edge following the mismatch cycle.
- Reset values: all lane and valid registers 0, so out_valid=0, out_data=0, out_error=0. Also err_sticky=0, err_count=0, err_fatal=0, consec=0.
- rst asserted mid-stream flushes every in-flight item. Nothing appears at the output after reset release.

## Structure
- Package dwc_pkg holds the default parameter constants (DWC_WIDTH, DWC_DEPTH, DWC_CNT_W, DWC_FATAL_THRESH) and a packed struct dwc_err_t {sticky, fatal, count} for consumers that bundle status.
- Sub-module dwc_lane (WIDTH, DEPTH): AND plus optional XOR mask plus DEPTH-stage register chain with synchronous reset. It is instantiated twice. The valid chain, comparator and error bookkeeping live in the top module.

## Test plan
- Reset: hold rst 2 cycles with random inputs → all outputs 0; out_valid stays 0 for DEPTH cycles after release.
- Latency, DEPTH=2: in_a=0xF0, in_b=0x3C, in_valid=1 at cycle 0 → out_data=0x30, out_valid=1 at cycle 2, out_error=0, err_count stays 0.
- Single fault: in_a=in_b=0xFF, fault_inj=0x01 → out_data=0xFF, out_error=1. Next cycle: err_sticky=1, err_count=1, err_fatal=0.
- Fatal threshold, FATAL_THRESH=3: faulty items valid at cycles 0, 1, bubble, 3 → err_fatal=1 one cycle after the third mismatch. Same sequence with a clean item between the 2nd and 3rd faulty items → err_fatal stays 0.
- Clear and mask: err_clear together with a mismatch → err_count=1, err_sticky=1. Faulty item with cmp_en=0 → out_error=0 and no counter change. err_clear never drops err_fatal; rst does.
- Saturation and reset mid-flight, CNT_W=2, FATAL_THRESH=3: 5 mismatches → err_count holds at 3. rst asserted with 2 items in flight → no out_valid after release.

Source files
------------

// File: rtl/dwc_pkg.sv
// Shared defaults and status bundle for the duplication-with-comparison AND stage.
package dwc_pkg;

  localparam int DWC_WIDTH        = 8;
  localparam int DWC_DEPTH        = 1;
  localparam int DWC_CNT_W        = 8;
  localparam int DWC_FATAL_THRESH = 3;

  typedef struct packed {
    logic                 sticky;
    logic                 fatal;
    logic [DWC_CNT_W-1:0] count;
  } dwc_err_t;

endpackage

// File: rtl/dwc_lane.sv
// One computation lane: masked AND feeding a DEPTH-stage register chain.
module dwc_lane #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] mask,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage [DEPTH];

  // Shifts every cycle regardless of validity; the valid chain lives in the top.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else begin
      stage[0] <= (a & b) ^ mask;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[DEPTH-1];

endmodule

// File: rtl/dwc_and_checker.sv
// Duplicated AND pipeline with lane comparison, sticky/saturating error
// bookkeeping and a consecutive-mismatch fatal alarm.
module dwc_and_checker
  import dwc_pkg::*;
#(
  parameter int WIDTH        = DWC_WIDTH,
  parameter int DEPTH        = DWC_DEPTH,
  parameter int CNT_W        = DWC_CNT_W,
  parameter int FATAL_THRESH = DWC_FATAL_THRESH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] fault_inj,
  input  logic             cmp_en,
  input  logic             err_clear,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_error,
  output logic             err_sticky,
  output logic [CNT_W-1:0] err_count,
  output logic             err_fatal
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] THRESH  = CNT_W'(FATAL_THRESH);

  logic [WIDTH-1:0] lane0_q;
  logic [WIDTH-1:0] lane1_q;
  logic [DEPTH-1:0] vld;
  logic [CNT_W-1:0] consec;
  logic [CNT_W-1:0] consec_nxt;
  logic [CNT_W-1:0] count_nxt;
  logic             sticky_nxt;
  logic             mismatch;

  dwc_lane #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_lane0 (
    .clk  (clk),
    .rst  (rst),
    .a    (in_a),
    .b    (in_b),
    .mask ('0),
    .q    (lane0_q)
  );

  dwc_lane #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_lane1 (
    .clk  (clk),
    .rst  (rst),
    .a    (in_a),
    .b    (in_b),
    .mask (fault_inj),
    .q    (lane1_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      vld <= '0;
    end else begin
      vld[0] <= in_valid;
      for (int i = 1; i < DEPTH; i++) vld[i] <= vld[i-1];
    end
  end

  assign out_valid = vld[DEPTH-1];
  assign out_data  = lane0_q;
  assign mismatch  = out_valid & cmp_en & (lane0_q != lane1_q);
  assign out_error = mismatch;

  // Clear takes effect first so a simultaneous mismatch is still recorded.
  always_comb begin
    sticky_nxt = err_clear ? 1'b0 : err_sticky;
    count_nxt  = err_clear ? '0   : err_count;
    consec_nxt = err_clear ? '0   : consec;
    if (mismatch) begin
      sticky_nxt = 1'b1;
      if (count_nxt  != CNT_MAX) count_nxt  = count_nxt  + CNT_W'(1);
      if (consec_nxt != CNT_MAX) consec_nxt = consec_nxt + CNT_W'(1);
    end else if (out_valid) begin
      consec_nxt = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_sticky <= 1'b0;
      err_count  <= '0;
      consec     <= '0;
      err_fatal  <= 1'b0;
    end else begin
      err_sticky <= sticky_nxt;
      err_count  <= count_nxt;
      consec     <= consec_nxt;
      if (consec_nxt >= THRESH) err_fatal <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dwc_and_checker.sv
// Directed and randomized checks of dwc_and_checker against a cycle-indexed reference model.
module tb_dwc_and_checker;

  localparam int W    = 8;
  localparam int D    = 2;
  localparam int CW   = 2;
  localparam int TH   = 3;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic [W-1:0]  in_a;
  logic [W-1:0]  in_b;
  logic [W-1:0]  fault_inj;
  logic          cmp_en;
  logic          err_clear;
  logic          out_valid;
  logic [W-1:0]  out_data;
  logic          out_error;
  logic          err_sticky;
  logic [CW-1:0] err_count;
  logic          err_fatal;

  int total = 0;
  int bad   = 0;

  // Reference model: what sits at each pipeline depth, plus error bookkeeping.
  logic         mv [D];
  logic [W-1:0] m0 [D];
  logic [W-1:0] m1 [D];
  int           m_count;
  int           m_consec;
  logic         m_sticky;
  logic         m_fatal;

  dwc_and_checker #(.WIDTH(W), .DEPTH(D), .CNT_W(CW), .FATAL_THRESH(TH)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_a       (in_a),
    .in_b       (in_b),
    .fault_inj  (fault_inj),
    .cmp_en     (cmp_en),
    .err_clear  (err_clear),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_error  (out_error),
    .err_sticky (err_sticky),
    .err_count  (err_count),
    .err_fatal  (err_fatal)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < D; i++) begin
      mv[i] = 1'b0;
      m0[i] = '0;
      m1[i] = '0;
    end
    m_count  = 0;
    m_consec = 0;
    m_sticky = 1'b0;
    m_fatal  = 1'b0;
  endtask

  // One clock: drive, check combinational error, advance model, check registers.
  task automatic tick(input logic r, input logic v, input logic [W-1:0] a,
                      input logic [W-1:0] b, input logic [W-1:0] f,
                      input logic ce, input logic clr);
    logic mm;
    rst = r; in_valid = v; in_a = a; in_b = b; fault_inj = f;
    cmp_en = ce; err_clear = clr;
    #1;
    mm = mv[D-1] && ce && (m0[D-1] != m1[D-1]);
    chk("out_error", {31'd0, out_error}, {31'd0, mm});
    @(posedge clk);
    if (r) begin
      model_reset();
    end else begin
      if (clr) begin
        m_sticky = 1'b0;
        m_count  = 0;
        m_consec = 0;
      end
      if (mm) begin
        m_sticky = 1'b1;
        m_count  = (m_count  < CMAX) ? m_count  + 1 : CMAX;
        m_consec = (m_consec < CMAX) ? m_consec + 1 : CMAX;
      end else if (mv[D-1]) begin
        m_consec = 0;
      end
      if (m_consec >= TH) m_fatal = 1'b1;
      for (int i = D - 1; i > 0; i--) begin
        mv[i] = mv[i-1];
        m0[i] = m0[i-1];
        m1[i] = m1[i-1];
      end
      mv[0] = v;
      m0[0] = a & b;
      m1[0] = (a & b) ^ f;
    end
    #1;
    chk("out_valid",  {31'd0, out_valid},  {31'd0, mv[D-1]});
    chk("out_data",   {24'd0, out_data},   {24'd0, m0[D-1]});
    chk("err_sticky", {31'd0, err_sticky}, {31'd0, m_sticky});
    chk("err_count",  {30'd0, err_count},  32'(m_count));
    chk("err_fatal",  {31'd0, err_fatal},  {31'd0, m_fatal});
  endtask

  task automatic idle();
    tick(1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic flt();
    tick(1'b0, 1'b1, 8'hFF, 8'hFF, 8'h01, 1'b1, 1'b0);
  endtask

  task automatic cln();
    tick(1'b0, 1'b1, 8'hA5, 8'h5A, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic do_rst();
    tick(1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0);
  endtask

  initial begin
    logic [W-1:0] ra, rb, rf;
    logic rr, rv, rce, rclr;

    model_reset();
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; fault_inj = '0;
    cmp_en = 1'b1; err_clear = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset held two cycles with random inputs, then release.
    for (int i = 0; i < 2; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rf = 8'($urandom);
      tick(1'b1, 1'b1, ra, rb, rf, 1'b1, 1'b0);
    end
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_data",  {24'd0, out_data},  32'd0);
    for (int i = 0; i < D - 1; i++) begin
      tick(1'b0, 1'b1, 8'hFF, 8'hFF, 8'h00, 1'b1, 1'b0);
      chk("rel_valid", {31'd0, out_valid}, 32'd0);
    end
    repeat (3) idle();

    // Latency with a clean item.
    tick(1'b0, 1'b1, 8'hF0, 8'h3C, 8'h00, 1'b1, 1'b0);
    idle();
    chk("lat_valid", {31'd0, out_valid}, 32'd1);
    chk("lat_data",  {24'd0, out_data},  32'h30);
    idle();
    chk("lat_count", {30'd0, err_count}, 32'd0);

    // Single injected fault.
    flt();
    idle();
    chk("sf_data",  {24'd0, out_data},  32'hFF);
    chk("sf_error", {31'd0, out_error}, 32'd1);
    idle();
    chk("sf_sticky", {31'd0, err_sticky}, 32'd1);
    chk("sf_count",  {30'd0, err_count},  32'd1);
    chk("sf_fatal",  {31'd0, err_fatal},  32'd0);

    // Fatal threshold across a bubble.
    do_rst();
    flt(); flt(); idle(); flt(); idle();
    chk("fat_pre", {31'd0, err_fatal}, 32'd0);
    idle();
    chk("fat_set", {31'd0, err_fatal}, 32'd1);

    // Clean item breaks the run.
    do_rst();
    flt(); flt(); cln(); flt(); idle(); idle(); idle();
    chk("fat_broken", {31'd0, err_fatal}, 32'd0);

    // Clear coincident with a mismatch.
    do_rst();
    flt(); flt(); idle(); idle();
    chk("clr_pre", {30'd0, err_count}, 32'd2);
    flt(); idle();
    tick(1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1);
    chk("clr_count",  {30'd0, err_count},  32'd1);
    chk("clr_sticky", {31'd0, err_sticky}, 32'd1);

    // Masked comparison.
    flt(); idle();
    tick(1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    chk("mask_count", {30'd0, err_count}, 32'd1);

    // err_clear leaves fatal alone; reset drops it.
    flt(); flt(); flt(); idle(); idle();
    chk("fc_set", {31'd0, err_fatal}, 32'd1);
    tick(1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1);
    chk("fc_keep",  {31'd0, err_fatal}, 32'd1);
    chk("fc_count", {30'd0, err_count}, 32'd0);
    do_rst();
    chk("fc_rst", {31'd0, err_fatal}, 32'd0);

    // Counter saturation.
    repeat (5) flt();
    idle(); idle();
    chk("sat_count", {30'd0, err_count}, 32'd3);

    // Reset with two items in flight.
    do_rst();
    cln(); cln();
    do_rst();
    for (int i = 0; i < 3; i++) begin
      idle();
      chk("flush_valid", {31'd0, out_valid}, 32'd0);
    end

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      rr   = ($urandom_range(0, 49) == 0);
      rv   = ($urandom_range(0, 3) != 0);
      ra   = 8'($urandom);
      rb   = 8'($urandom);
      rf   = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
      rce  = ($urandom_range(0, 7) != 0);
      rclr = ($urandom_range(0, 15) == 0);
      tick(rr, rv, ra, rb, rf, rce, rclr);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
